// File: rtl/commit_monitor.sv
// commit_monitor: retirement monitor for a simulated core.
//   Counts retired instructions and cycles spent running, watches for a
//   stalled pipeline (watchdog), captures the exit code carried by the
//   terminating ebreak, and optionally streams retired PCs out through a
//   small trace FIFO.
//
// Ports:
//   clock, reset (sync, active-low)
//   io_in_*      retirement handshake from write-back (valid/ready, pc, isEnd, a0)
//   io_done/io_pass/io_exitCode   program end status
//   io_instret/io_cycles          64-bit retired-instruction and run-cycle counters
//   io_timeout                    watchdog expired
//   io_trace_*                    retired-PC stream (valid/ready, pc)
//
// Build option: define COMMIT_MONITOR_TRACE_EN to include the trace FIFO.
// Without it the trace stream is tied off and io_trace_ready is ignored.
module commit_monitor #(
  parameter int unsigned WATCHDOG_CYCLES = 10000,
  parameter int unsigned TRACE_DEPTH     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [31:0] io_in_bits_pc,
  input  logic        io_in_bits_isEnd,
  input  logic [31:0] io_in_bits_a0,
  output logic        io_done,
  output logic        io_pass,
  output logic [31:0] io_exitCode,
  output logic [63:0] io_instret,
  output logic [63:0] io_cycles,
  output logic        io_timeout,
  output logic        io_trace_valid,
  input  logic        io_trace_ready,
  output logic [31:0] io_trace_pc
);

  localparam int unsigned WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd;
  logic            fifo_room;
  logic            commit;

  assign io_in_ready = (state == S_RUN) && fifo_room;
  assign commit      = io_in_valid && io_in_ready;
  assign io_done     = (state == S_DONE);
  assign io_timeout  = (state == S_TIMEOUT);

  always_ff @(posedge clock) begin
    if (!reset) state <= S_RUN;
    else        state <= state_nxt;
  end

  // A commit in the expiry cycle takes priority and keeps the core running.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (commit) begin
          if (io_in_bits_isEnd) state_nxt = S_DONE;
        end else if (wd == WD_LAST) begin
          state_nxt = S_TIMEOUT;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      io_instret  <= '0;
      io_cycles   <= '0;
      wd          <= '0;
      io_exitCode <= '0;
      io_pass     <= 1'b0;
    end else if (state == S_RUN) begin
      io_cycles <= io_cycles + 64'd1;
      if (commit) begin
        io_instret <= io_instret + 64'd1;
        wd         <= '0;
        if (io_in_bits_isEnd) begin
          io_exitCode <= io_in_bits_a0;
          io_pass     <= (io_in_bits_a0 == 32'd0);
        end
      end else begin
        wd <= wd + 1'b1;
      end
    end
  end

`ifdef COMMIT_MONITOR_TRACE_EN
  localparam int unsigned AW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

  logic [31:0]   mem [TRACE_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  // Fullness comes from the registered count only, so a pop in the same
  // cycle does not free a slot for the incoming retirement.
  assign fifo_room      = (count != (AW+1)'(TRACE_DEPTH));
  assign push           = commit;
  assign pop            = io_trace_valid && io_trace_ready;
  assign io_trace_valid = (count != '0);
  assign io_trace_pc    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= io_in_bits_pc;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`else
  logic unused_trace;
  assign unused_trace   = ^{io_trace_ready, io_in_bits_pc};
  assign fifo_room      = 1'b1;
  assign io_trace_valid = 1'b0;
  assign io_trace_pc    = '0;
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// tb_commit_monitor: randomized and directed stimulus for commit_monitor,
// checked every cycle against a behavioural model (mode flag, idle-cycle
// count, queue of traced PCs). Works with or without COMMIT_MONITOR_TRACE_EN.
module tb_commit_monitor;

  localparam int unsigned WD    = 16;
  localparam int unsigned DEPTH = 8;
`ifdef COMMIT_MONITOR_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif
  localparam int M_RUN = 0, M_DONE = 1, M_TIMEOUT = 2;

  logic        clock;
  logic        rst;
  logic        v;
  logic        in_ready;
  logic [31:0] pc;
  logic        isend;
  logic [31:0] a0;
  logic        done, pass, timeout;
  logic [31:0] exit_code;
  logic [63:0] instret, cycles;
  logic        tvalid;
  logic        tready;
  logic [31:0] tpc;

  commit_monitor #(.WATCHDOG_CYCLES(WD), .TRACE_DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (rst),
    .io_in_valid      (v),
    .io_in_ready      (in_ready),
    .io_in_bits_pc    (pc),
    .io_in_bits_isEnd (isend),
    .io_in_bits_a0    (a0),
    .io_done          (done),
    .io_pass          (pass),
    .io_exitCode      (exit_code),
    .io_instret       (instret),
    .io_cycles        (cycles),
    .io_timeout       (timeout),
    .io_trace_valid   (tvalid),
    .io_trace_ready   (tready),
    .io_trace_pc      (tpc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model
  int              mode      = M_RUN;
  longint unsigned m_instret = 0;
  longint unsigned m_cycles  = 0;
  int              idle      = 0;
  logic [31:0]     m_exit    = '0;
  logic            m_pass    = 1'b0;
  logic [31:0]     q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (mode == M_RUN) && (!TRACE || q.size() < DEPTH);
  endfunction

  task automatic model_update();
    bit rdy, com, popd;
    if (!rst) begin
      mode = M_RUN; m_instret = 0; m_cycles = 0; idle = 0;
      m_exit = '0; m_pass = 1'b0; q.delete();
    end else begin
      rdy  = model_ready();
      com  = v && rdy;
      popd = TRACE && (q.size() > 0) && tready;
      if (popd) void'(q.pop_front());
      if (mode == M_RUN) begin
        m_cycles++;
        if (com) begin
          m_instret++;
          idle = 0;
          if (TRACE) q.push_back(pc);
          if (isend) begin
            m_exit = a0; m_pass = (a0 == 0); mode = M_DONE;
          end
        end else if (idle == WD - 1) begin
          mode = M_TIMEOUT;
        end else begin
          idle++;
        end
      end
    end
  endtask

  // One clock: check handshake outputs for the current inputs, clock the
  // DUT and the model, then check registered outputs.
  task automatic step();
    #1;
    check("in_ready", in_ready, model_ready());
    check("trace_valid", tvalid, TRACE && q.size() > 0);
    if (!TRACE) check("trace_pc_tied", tpc, 0);
    else if (q.size() > 0) check("trace_pc", tpc, q[0]);
    @(posedge clock);
    model_update();
    #1;
    check("done", done, mode == M_DONE);
    check("timeout", timeout, mode == M_TIMEOUT);
    check("pass", pass, m_pass);
    check("exitCode", exit_code, m_exit);
    check("instret", instret, m_instret);
    check("cycles", cycles, m_cycles);
  endtask

  task automatic drive(input logic vv, input logic [31:0] p, input logic e, input logic [31:0] a);
    v = vv; pc = p; isend = e; a0 = a;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    int pct_v;
    int k;
    rst = 1'b0; tready = 1'b1;
    drive(1'b0, '0, 1'b0, '0);
    @(posedge clock);
    #1;

    // Reset state
    do_reset();
    check("rst_done", done, 0);
    check("rst_instret", instret, 0);
    check("rst_exit", exit_code, 0);
    check("rst_tvalid", tvalid, 0);

    // Five commits, last is the ending ebreak with a0 == 0
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h8000_0000 + 32'(4 * i), i == 4, '0);
      step();
    end
    drive(1'b0, '0, 1'b0, '0);
    check("e1_done", done, 1);
    check("e1_pass", pass, 1);
    check("e1_exit", exit_code, 0);
    check("e1_instret", instret, 5);
    step(); step();

    // Failing exit code; further retirements are refused
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), i == 2, 32'h1);
      step();
    end
    check("e2_pass", pass, 0);
    check("e2_exit", exit_code, 1);
    drive(1'b1, 32'h200, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step();
    check("e2_ready", in_ready, 0);
    check("e2_instret", instret, 3);

    // Watchdog expiry with no retirements
    drive(1'b0, '0, 1'b0, '0);
    do_reset();
    for (int i = 0; i < 15; i++) step();
    check("wd_early", timeout, 0);
    step();
    check("wd_timeout", timeout, 1);
    check("wd_cycles", cycles, 16);
    check("wd_done", done, 0);
    step(); step();
    check("wd_frozen", cycles, 16);

    // Commit exactly in the expiry cycle rescues the run
    do_reset();
    for (int i = 0; i < 15; i++) step();
    drive(1'b1, 32'h300, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, '0);
    check("wd_rescue", timeout, 0);
    for (int i = 0; i < 15; i++) step();
    check("wd_restart_early", timeout, 0);
    step();
    check("wd_restart_exp", timeout, 1);
    check("wd_restart_cyc", cycles, 32);

    // Trace backpressure: 10 offered, sink stalled, then released
    do_reset();
    tready = 1'b0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      drive(k < 10, 32'h8000_0000 + 32'(4 * k), 1'b0, '0);
      #1;
      if (v && in_ready) k++;
      step();
    end
    if (TRACE) check("tr_accepted", instret, 8);
    else       check("tr_accepted", instret, 10);
    tready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(k < 10, 32'h8000_0000 + 32'(4 * k), 1'b0, '0);
      #1;
      if (v && in_ready) k++;
      step();
    end
    check("tr_all", instret, 10);

    // Reset mid-stream, with a retirement presented during reset
    drive(1'b0, '0, 1'b0, '0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i), 1'b0, 32'h5);
      step();
    end
    rst = 1'b0;
    step();
    check("mr_instret", instret, 0);
    check("mr_cycles", cycles, 0);
    check("mr_tvalid", tvalid, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 32'h5);
      step();
    end
    check("mr_resume", instret, 3);

    // Randomized epochs with varying retirement density
    for (int ep = 0; ep < 20; ep++) begin
      case (ep % 4)
        0: pct_v = 90;
        1: pct_v = 50;
        2: pct_v = 5;
        default: pct_v = 0;
      endcase
      do_reset();
      for (int c = 0; c < 150; c++) begin
        drive($urandom_range(0, 99) < pct_v, $urandom(),
              $urandom_range(0, 99) < 2,
              ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom());
        tready = ($urandom_range(0, 99) < 60);
        rst = ($urandom_range(0, 199) != 0);
        step();
      end
      rst = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
